// File: rtl/ascon_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ascon_pack : shared state encoding and round constants for ascon_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package ascon_pack;

  localparam int         ROUNDS_A_C   = 12;
  localparam int         ROUNDS_B_C   = 6;
  localparam logic [3:0] ROUND_LAST_C = 4'd11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    WAIT_AD = 3'd2,
    AD      = 3'd3,
    WAIT_PT = 3'd4,
    PT      = 3'd5,
    FINAL   = 3'd6,
    DONE    = 3'd7
  } ascon_state_t;

endpackage

`default_nettype wire

// File: rtl/ascon_round_counter.sv
// ---------------------------------------------------------------------------
// ascon_round_counter : 4-bit round index, saturating at the last round
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ascon_round_counter
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  output logic [3:0] count_o,
  output logic       last_o
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Load wins over increment; the count parks at the last round index.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != ROUND_LAST_C)) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == ROUND_LAST_C);

endmodule

`default_nettype wire

// File: rtl/ascon_sequencer.sv
// ---------------------------------------------------------------------------
// ascon_sequencer : control FSM for one ASCON-128 encryption, one round/clock
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ascon_sequencer
  import ascon_pack::*;
#(
  parameter int ROUNDS_A = ROUNDS_A_C,
  parameter int ROUNDS_B = ROUNDS_B_C
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic       last_i,
  output logic       data_ready_o,
  output logic       en_key_o,
  output logic       en_data_o,
  output logic       en_state_o,
  output logic       init_sel_o,
  output logic [3:0] round_o,
  output logic       xor_data_o,
  output logic       xor_key_begin_o,
  output logic       xor_key_end_o,
  output logic       xor_domain_o,
  output logic       en_cipher_o,
  output logic       cipher_valid_o,
  output logic       en_tag_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [3:0] LOAD_A_C = ROUND_LAST_C + 4'd1 - 4'(ROUNDS_A);
  localparam logic [3:0] LOAD_B_C = ROUND_LAST_C + 4'd1 - 4'(ROUNDS_B);

  ascon_state_t state_q;
  logic         cipher_valid_q;
  logic [3:0]   count;
  logic         count_last;
  logic         cnt_load;
  logic [3:0]   cnt_load_val;
  logic         cnt_en;
  logic         in_wait;
  logic         in_round;
  logic         transfer;

  assign in_wait  = (state_q == WAIT_AD) || (state_q == WAIT_PT);
  assign in_round = (state_q == INIT) || (state_q == AD) ||
                    (state_q == PT)   || (state_q == FINAL);
  assign transfer = in_wait && data_valid_i;

  // Init and final phases run p^a; every data-phase entry runs p^b.
  assign cnt_load     = ((state_q == IDLE) && start_i) || transfer;
  assign cnt_load_val = ((state_q == IDLE) || ((state_q == WAIT_PT) && last_i))
                        ? LOAD_A_C : LOAD_B_C;
  assign cnt_en       = in_round;

  ascon_round_counter u_round_counter (
    .clock_i    (clock_i),
    .resetb_i   (resetb_i),
    .load_i     (cnt_load),
    .load_val_i (cnt_load_val),
    .en_i       (cnt_en),
    .count_o    (count),
    .last_o     (count_last)
  );

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      state_q        <= IDLE;
      cipher_valid_q <= 1'b0;
    end else begin
      cipher_valid_q <= en_cipher_o;
      case (state_q)
        IDLE:    if (start_i)      state_q <= INIT;
        INIT:    if (count_last)   state_q <= WAIT_AD;
        WAIT_AD: if (data_valid_i) state_q <= AD;
        AD:      if (count_last)   state_q <= WAIT_PT;
        WAIT_PT: if (data_valid_i) state_q <= last_i ? FINAL : PT;
        PT:      if (count_last)   state_q <= WAIT_PT;
        FINAL:   if (count_last)   state_q <= DONE;
        DONE:                      state_q <= IDLE;
        default:                   state_q <= IDLE;
      endcase
    end
  end

  // en_key_o is gated by reset so that every strobe reads 0 while held in reset.
  assign en_key_o       = resetb_i && start_i && (state_q == IDLE);
  assign en_data_o      = transfer;
  assign data_ready_o   = in_wait;
  assign en_state_o     = in_round;
  assign round_o        = count;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = (state_q == DONE);
  assign cipher_valid_o = cipher_valid_q;

  always_comb begin
    init_sel_o      = 1'b0;
    xor_data_o      = 1'b0;
    xor_key_begin_o = 1'b0;
    xor_key_end_o   = 1'b0;
    xor_domain_o    = 1'b0;
    en_cipher_o     = 1'b0;
    en_tag_o        = 1'b0;
    case (state_q)
      INIT: begin
        init_sel_o    = (count == LOAD_A_C);
        xor_key_end_o = count_last;
      end
      AD: begin
        xor_data_o   = (count == LOAD_B_C);
        xor_domain_o = count_last;
      end
      PT: begin
        xor_data_o  = (count == LOAD_B_C);
        en_cipher_o = (count == LOAD_B_C);
      end
      FINAL: begin
        xor_data_o      = (count == LOAD_A_C);
        en_cipher_o     = (count == LOAD_A_C);
        xor_key_begin_o = (count == LOAD_A_C);
        xor_key_end_o   = count_last;
        en_tag_o        = count_last;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_ascon_sequencer.sv
// ---------------------------------------------------------------------------
// tb_ascon_sequencer : directed cycle-by-cycle checks of ascon_sequencer
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ascon_sequencer;

  logic clock = 1'b0;
  logic resetb = 1'b0;
  logic start = 1'b0;
  logic start8 = 1'b0;
  logic dv = 1'b0;
  logic last = 1'b0;

  logic       rdy, ekey, edata, estate, isel, xdata, xkb, xke, xdom, eciph, cv, etag, busy, done;
  logic [3:0] round;
  logic       rdy8, ekey8, edata8, estate8, isel8, xdata8, xkb8, xke8, xdom8, eciph8, cv8, etag8, busy8, done8;
  logic [3:0] round8;
  logic [13:0] all_bits;

  int checks = 0;
  int failures = 0;

  logic [63:0] h_key, h_data, h_state, h_init, h_xdata, h_kb, h_ke, h_dom, h_ciph, h_cv, h_tag, h_busy, h_done, h_rdy;
  logic [63:0] h8_state, h8_dom, h8_done;
  logic [3:0]  h_round [64];
  logic [3:0]  h8_round [64];

  assign all_bits = {rdy, ekey, edata, estate, isel, xdata, xkb, xke, xdom, eciph, cv, etag, busy, done};

  always #5 clock = ~clock;

  ascon_sequencer dut (
    .clock_i(clock), .resetb_i(resetb), .start_i(start), .data_valid_i(dv), .last_i(last),
    .data_ready_o(rdy), .en_key_o(ekey), .en_data_o(edata), .en_state_o(estate),
    .init_sel_o(isel), .round_o(round), .xor_data_o(xdata), .xor_key_begin_o(xkb),
    .xor_key_end_o(xke), .xor_domain_o(xdom), .en_cipher_o(eciph), .cipher_valid_o(cv),
    .en_tag_o(etag), .busy_o(busy), .done_o(done)
  );

  ascon_sequencer #(.ROUNDS_B(8)) dut8 (
    .clock_i(clock), .resetb_i(resetb), .start_i(start8), .data_valid_i(dv), .last_i(last),
    .data_ready_o(rdy8), .en_key_o(ekey8), .en_data_o(edata8), .en_state_o(estate8),
    .init_sel_o(isel8), .round_o(round8), .xor_data_o(xdata8), .xor_key_begin_o(xkb8),
    .xor_key_end_o(xke8), .xor_domain_o(xdom8), .en_cipher_o(eciph8), .cipher_valid_o(cv8),
    .en_tag_o(etag8), .busy_o(busy8), .done_o(done8)
  );

  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic apply_reset();
    resetb = 1'b0; start = 1'b0; start8 = 1'b0; dv = 1'b0; last = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock); resetb = 1'b1;
    @(posedge clock); #1;
  endtask

  // mode 0 single block, 1 three blocks, 2 noisy start/valid, 3 AD stall, 4 ROUNDS_B=8 instance
  task automatic run_cycles(input int n, input int mode);
    {h_key, h_data, h_state, h_init, h_xdata, h_kb, h_ke, h_dom, h_ciph, h_cv, h_tag, h_busy, h_done, h_rdy} = '0;
    {h8_state, h8_dom, h8_done} = '0;
    for (int c = 0; c < n; c++) begin
      start  = (mode != 4) && ((c == 0) || ((mode == 2) && (c == 15 || c == 17 || c == 23 || c == 27 || c == 30)));
      start8 = (mode == 4) && (c == 0);
      if (mode == 2)      dv = (c == 13 || c == 20) ? 1'b1 : (c % 2 == 1);
      else if (mode == 3) dv = !(c >= 13 && c <= 22);
      else                dv = 1'b1;
      last = (mode == 1) ? (c >= 30) : 1'b1;
      #2;
      h_key[c] = ekey;   h_data[c] = edata;  h_state[c] = estate; h_init[c] = isel;
      h_xdata[c] = xdata; h_kb[c] = xkb;     h_ke[c] = xke;       h_dom[c] = xdom;
      h_ciph[c] = eciph; h_cv[c] = cv;       h_tag[c] = etag;     h_busy[c] = busy;
      h_done[c] = done;  h_rdy[c] = rdy;     h_round[c] = round;
      h8_state[c] = estate8; h8_dom[c] = xdom8; h8_done[c] = done8; h8_round[c] = round8;
      @(posedge clock); #1;
    end
    start = 1'b0; start8 = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (all_bits !== 14'd0) begin failures++; $display("FAIL reset_outputs got=%b exp=0", all_bits); end
    checks++; if (round !== 4'd0) begin failures++; $display("FAIL reset_round got=%0d exp=0", round); end
    start = 1'b1; #1;
    checks++; if (ekey !== 1'b1) begin failures++; $display("FAIL start_en_key got=%b exp=1", ekey); end
    @(posedge clock); #1; start = 1'b0;
    repeat (4) begin @(posedge clock); #1; end
    checks++; if (round !== 4'd4) begin failures++; $display("FAIL init_cycle5_round got=%0d exp=4", round); end
    resetb = 1'b0; #1;
    checks++; if (all_bits !== 14'd0) begin failures++; $display("FAIL midinit_reset_outputs got=%b exp=0", all_bits); end
    checks++; if (round !== 4'd0) begin failures++; $display("FAIL midinit_reset_round got=%0d exp=0", round); end
    @(negedge clock); resetb = 1'b1;
    @(posedge clock); #1;
    start = 1'b1; #1;
    checks++; if (ekey !== 1'b1) begin failures++; $display("FAIL restart_en_key got=%b exp=1", ekey); end
    @(posedge clock); #1; start = 1'b0; #1;
    checks++; if ({round, isel, estate, busy} !== {4'd0, 3'b111}) begin
      failures++; $display("FAIL restart_init round=%0d sel=%b st=%b busy=%b exp=0,1,1,1", round, isel, estate, busy);
    end
  endtask

  task automatic test_single_block();
    apply_reset();
    run_cycles(41, 0);
    checks++; if (h_key !== rng(0, 0)) begin failures++; $display("FAIL single_en_key got=%h exp=%h", h_key, rng(0, 0)); end
    checks++; if (h_init !== rng(1, 1)) begin failures++; $display("FAIL single_init_sel got=%h exp=%h", h_init, rng(1, 1)); end
    checks++; if (h_state !== (rng(1, 12) | rng(14, 19) | rng(21, 32))) begin failures++; $display("FAIL single_en_state got=%h", h_state); end
    checks++; if (h_rdy !== (rng(13, 13) | rng(20, 20))) begin failures++; $display("FAIL single_ready got=%h", h_rdy); end
    checks++; if (h_data !== (rng(13, 13) | rng(20, 20))) begin failures++; $display("FAIL single_en_data got=%h", h_data); end
    checks++; if (h_xdata !== (rng(14, 14) | rng(21, 21))) begin failures++; $display("FAIL single_xor_data got=%h", h_xdata); end
    checks++; if (h_dom !== rng(19, 19)) begin failures++; $display("FAIL single_xor_domain got=%h exp=%h", h_dom, rng(19, 19)); end
    checks++; if (h_kb !== rng(21, 21)) begin failures++; $display("FAIL single_key_begin got=%h exp=%h", h_kb, rng(21, 21)); end
    checks++; if (h_ke !== (rng(12, 12) | rng(32, 32))) begin failures++; $display("FAIL single_key_end got=%h", h_ke); end
    checks++; if (h_ciph !== rng(21, 21)) begin failures++; $display("FAIL single_en_cipher got=%h", h_ciph); end
    checks++; if (h_cv !== rng(22, 22)) begin failures++; $display("FAIL single_cipher_valid got=%h", h_cv); end
    checks++; if (h_tag !== rng(32, 32)) begin failures++; $display("FAIL single_en_tag got=%h", h_tag); end
    checks++; if (h_done !== rng(33, 33)) begin failures++; $display("FAIL single_done got=%h", h_done); end
    checks++; if (h_busy !== rng(1, 33)) begin failures++; $display("FAIL single_busy got=%h", h_busy); end
    checks++; if ({h_round[1], h_round[12], h_round[13], h_round[14], h_round[19], h_round[21], h_round[32]}
                  !== {4'd0, 4'd11, 4'd11, 4'd6, 4'd11, 4'd0, 4'd11}) begin
      failures++; $display("FAIL single_round r1=%0d r12=%0d r13=%0d r14=%0d r19=%0d r21=%0d r32=%0d",
                           h_round[1], h_round[12], h_round[13], h_round[14], h_round[19], h_round[21], h_round[32]);
    end
  endtask

  task automatic test_three_blocks();
    apply_reset();
    run_cycles(51, 1);
    checks++; if (h_ciph !== (rng(21, 21) | rng(28, 28) | rng(35, 35))) begin failures++; $display("FAIL multi_en_cipher got=%h", h_ciph); end
    checks++; if (h_cv !== (rng(22, 22) | rng(29, 29) | rng(36, 36))) begin failures++; $display("FAIL multi_cipher_valid got=%h", h_cv); end
    checks++; if (h_state !== (rng(1, 12) | rng(14, 19) | rng(21, 26) | rng(28, 33) | rng(35, 46))) begin failures++; $display("FAIL multi_en_state got=%h", h_state); end
    checks++; if (h_rdy !== (rng(13, 13) | rng(20, 20) | rng(27, 27) | rng(34, 34))) begin failures++; $display("FAIL multi_ready got=%h", h_rdy); end
    checks++; if (h_kb !== rng(35, 35)) begin failures++; $display("FAIL multi_key_begin got=%h", h_kb); end
    checks++; if (h_tag !== rng(46, 46)) begin failures++; $display("FAIL multi_en_tag got=%h", h_tag); end
    checks++; if (h_done !== rng(47, 47)) begin failures++; $display("FAIL multi_done got=%h", h_done); end
    checks++; if ({h_round[21], h_round[26], h_round[27], h_round[28]} !== {4'd6, 4'd11, 4'd11, 4'd6}) begin
      failures++; $display("FAIL multi_round r21=%0d r26=%0d r27=%0d r28=%0d exp=6,11,11,6", h_round[21], h_round[26], h_round[27], h_round[28]);
    end
  endtask

  task automatic test_ignored_inputs();
    apply_reset();
    run_cycles(41, 2);
    checks++; if (h_key !== rng(0, 0)) begin failures++; $display("FAIL noise_en_key got=%h", h_key); end
    checks++; if (h_data !== (rng(13, 13) | rng(20, 20))) begin failures++; $display("FAIL noise_en_data got=%h", h_data); end
    checks++; if (h_state !== (rng(1, 12) | rng(14, 19) | rng(21, 32))) begin failures++; $display("FAIL noise_en_state got=%h", h_state); end
    checks++; if (h_dom !== rng(19, 19)) begin failures++; $display("FAIL noise_xor_domain got=%h", h_dom); end
    checks++; if (h_done !== rng(33, 33)) begin failures++; $display("FAIL noise_done got=%h", h_done); end
  endtask

  task automatic test_stall();
    logic held;
    apply_reset();
    run_cycles(45, 3);
    held = 1'b1;
    for (int c = 13; c <= 23; c++) if (h_round[c] !== 4'd11) held = 1'b0;
    checks++; if (!held) begin failures++; $display("FAIL stall_round_held got=0 exp=1"); end
    checks++; if (h_rdy !== (rng(13, 23) | rng(30, 30))) begin failures++; $display("FAIL stall_ready got=%h", h_rdy); end
    checks++; if (h_state !== (rng(1, 12) | rng(24, 29) | rng(31, 42))) begin failures++; $display("FAIL stall_en_state got=%h", h_state); end
    checks++; if (h_data !== (rng(23, 23) | rng(30, 30))) begin failures++; $display("FAIL stall_en_data got=%h", h_data); end
    checks++; if (h_xdata !== (rng(24, 24) | rng(31, 31))) begin failures++; $display("FAIL stall_xor_data got=%h", h_xdata); end
    checks++; if (h_round[24] !== 4'd6) begin failures++; $display("FAIL stall_ad_round got=%0d exp=6", h_round[24]); end
    checks++; if (h_done !== rng(43, 43)) begin failures++; $display("FAIL stall_done got=%h", h_done); end
  endtask

  task automatic test_rounds_b8();
    apply_reset();
    run_cycles(40, 4);
    checks++; if (h8_state !== (rng(1, 12) | rng(14, 21) | rng(23, 34))) begin failures++; $display("FAIL b8_en_state got=%h", h8_state); end
    checks++; if (h8_dom !== rng(21, 21)) begin failures++; $display("FAIL b8_xor_domain got=%h", h8_dom); end
    checks++; if (h8_done !== rng(35, 35)) begin failures++; $display("FAIL b8_done got=%h", h8_done); end
    checks++; if ({h8_round[14], h8_round[15], h8_round[21]} !== {4'd4, 4'd5, 4'd11}) begin
      failures++; $display("FAIL b8_round r14=%0d r15=%0d r21=%0d exp=4,5,11", h8_round[14], h8_round[15], h8_round[21]);
    end
    checks++; if (h_busy !== 64'd0) begin failures++; $display("FAIL b8_main_idle got=%h exp=0", h_busy); end
  endtask

  initial begin
    test_reset();
    test_single_block();
    test_three_blocks();
    test_ignored_inputs();
    test_stall();
    test_rounds_b8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ascon_sequencer.md
# ascon_sequencer

Control FSM that sequences one ASCON-128 encryption on the shared permutation datapath: key and state loading, the 12-round initialisation, one associated-data block, N plaintext blocks and the 12-round finalisation. It drives the enables of the 128-bit key, state, ciphertext and tag registers, the round index for constant addition, and the key, data and domain XOR strobes. It sits between the top-level host handshake and the permutation/register datapath, executing one permutation round per clock.

## Interface
- ROUNDS_A, 12, rounds for init/final permutation p^a
- ROUNDS_B, 6, rounds for data-phase permutation p^b
- clock_i  in  1  clock
- resetb_i  in  1  reset, asynchronous, active-low
- start_i  in  1  start request, sampled only in IDLE
- data_valid_i  in  1  64-bit AD/PT block available on datapath input
- last_i  in  1  qualifies data_valid_i in WAIT_PT: final plaintext block
- data_ready_o  out  1  controller accepts a block (WAIT_AD, WAIT_PT)
- en_key_o  out  1  key register load (Mealy: start_i & IDLE)
- en_data_o  out  1  data register load (Mealy: data_valid_i & data_ready_o)
- en_state_o  out  1  state register enable, high every round cycle
- init_sel_o  out  1  state mux selects IV||K||N instead of feedback
- round_o  out  4  round index for constant addition, 0..11
- xor_data_o  out  1  XOR data block into rate before the round
- xor_key_begin_o  out  1  XOR 0^64||K into state before the round
- xor_key_end_o  out  1  XOR K into last 128 bits after the round
- xor_domain_o  out  1  XOR 1 into state LSB after the round
- en_cipher_o  out  1  ciphertext register load
- cipher_valid_o  out  1  ciphertext register holds a fresh block (1 cycle)
- en_tag_o  out  1  tag register load
- busy_o  out  1  state != IDLE
- done_o  out  1  tag valid, 1-cycle pulse

## Operation
- States: IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE.
- IDLE: start_i=1 -> INIT. en_key_o=1 in the same cycle. start_i is ignored in all other states.
- INIT: ROUNDS_A cycles. round_o runs 12-ROUNDS_A..11. init_sel_o=1 on the first round only. xor_key_end_o=1 on round 11. Then -> WAIT_AD.
- WAIT_AD: data_ready_o=1. A transfer (en_data_o=1) -> AD.
- AD: ROUNDS_B cycles. round_o runs 12-ROUNDS_B..11. xor_data_o=1 on the first round. xor_domain_o=1 on round 11. Then -> WAIT_PT.
- WAIT_PT: data_ready_o=1. On transfer: last_i=0 -> PT; last_i=1 -> FINAL.
- PT: en_cipher_o=1 and xor_data_o=1 on the first round. Runs ROUNDS_B rounds, then -> WAIT_PT.
- FINAL: ROUNDS_A rounds.
  - First round: en_cipher_o=1, xor_data_o=1, xor_key_begin_o=1.
  - Round 11: xor_key_end_o=1 and en_tag_o=1. Then -> DONE.
- DONE: done_o=1 for one cycle, then -> IDLE.
- cipher_valid_o is high the cycle after en_cipher_o.
- en_state_o=1 in every INIT/AD/PT/FINAL cycle and 0 elsewhere.
- data_valid_i outside WAIT_* is ignored: no en_data_o, no state change.
- Round counter:
  - 4-bit, loaded with 12-ROUNDS on each phase entry.
  - Increments every round cycle; the phase ends when it equals 11.
  - Never wraps past 11.
  - Holds its value in IDLE and WAIT states.

## Timing
- Reset (async, any state): state=IDLE, counter=0, round_o=0, all single-bit outputs 0.
- Reset mid-operation abandons the message. There is no partial-result output.
- All outputs except en_key_o and en_data_o are registered or decoded from state/counter (Moore).
- Reference sequence, with start at cycle 0 and data_valid_i always high:
  - INIT: cycles 1-12.
  - WAIT_AD: cycle 13.
  - AD: cycles 14-19.
  - WAIT_PT: cycle 20.
  - For a single block with last_i=1: FINAL cycles 21-32, en_tag_o at 32, done_o at 33, IDLE at 34.
- Each non-last PT block adds 1 + ROUNDS_B = 7 cycles.
- Stalling data_valid_i low holds WAIT_* indefinitely, with round_o and registers frozen.

## Structure
- ascon_pack holds:
  - the state enum typedef `ascon_state_t`;
  - constants ROUNDS_A_C=12, ROUNDS_B_C=6, and ROUND_LAST_C=11.
- Sub-module ascon_round_counter: 4-bit counter with load value, enable, and a last flag (count==11). It is instantiated once.
- The controller is the FSM plus output decode only. It contains no datapath.

## Test plan
- Reset mid-INIT (cycle 5): all outputs 0 immediately. A new start_i then gives INIT round_o=0 one cycle later.
- Single AD + single PT block (last_i=1), inputs always valid -> the following cycles:
  - en_key_o at 0, init_sel_o at 1, xor_key_end_o at 12;
  - xor_domain_o at 19;
  - xor_key_begin_o at 21, en_tag_o at 32, done_o at 33.
- Three PT blocks (last on third) -> en_cipher_o at cycles 21, 28, 35. cipher_valid_o one cycle after each. done_o at 47.
- data_valid_i low 10 cycles in WAIT_AD -> data_ready_o stays 1, en_state_o=0, and round_o is held throughout. AD starts the cycle after the transfer.
- start_i pulses during AD and PT, and data_valid_i toggles during rounds -> no effect on sequence timing.
- ROUNDS_B=8 parameter override -> AD round_o runs 4..11, 8 cycles.
